// File: rtl/apb_master_bridge_if.sv
// Bundles the local command/response port and the APB bus of apb_master_bridge.
// The bridge connects through 'master'; the environment (requester + completer) through 'slave'.
interface apb_master_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: one local command becomes one SETUP/ACCESS transfer
// and one response, with wait-state timeout and optional registered-read sample cycle.
module apb_master_bridge #(
  parameter int TIMEOUT = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_master_bridge_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [2:0]    state_q, state_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d       = bus.cmd_addr;
          pwdata_d      = bus.cmd_wdata;
          pwrite_d      = bus.cmd_write;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          wait_cnt_d    = '0;
          state_d       = S_SETUP;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else if (pwrite_q) begin
            state_d = S_RESP;
          end else if (RD_LAT == 0) begin
            rsp_rdata_d = bus.prdata;
            state_d     = S_RESP;
          end else begin
            state_d = S_RDWAIT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // wait_cnt_q counts the low cycles already seen, so this is the TIMEOUT-th one.
          if (TIMEOUT != 0 && wait_cnt_q == WAIT_LAST) begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = S_RESP;
          end
        end
      end

      S_RDWAIT: begin
        rsp_rdata_d = bus.prdata;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= S_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Every output is a flop or a decode of state_q; nothing passes straight through.
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable     = (state_q == S_ACCESS);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  a_access_stable: assert property (@(posedge pclk) disable iff (preset)
    (state_q == S_ACCESS) |-> ($stable(paddr_q) && $stable(pwdata_q) && $stable(pwrite_q)));

  a_resp_stable: assert property (@(posedge pclk) disable iff (preset)
    ((state_q == S_RESP) && $past(state_q == S_RESP)) |->
      ($stable(rsp_rdata_q) && $stable(rsp_err_q) && $stable(rsp_timeout_q)));

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a registered-read instance (RD_LAT=1, TIMEOUT=16)
// and a combinational-read instance (RD_LAT=0, TIMEOUT=0), each with a small APB memory model.
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  apb_master_bridge_if bus1 ();
  apb_master_bridge_if bus0 ();

  apb_master_bridge #(.TIMEOUT(16), .RD_LAT(1)) u_dut1 (.pclk(pclk), .preset(preset), .bus(bus1));
  apb_master_bridge #(.TIMEOUT(0),  .RD_LAT(0)) u_dut0 (.pclk(pclk), .preset(preset), .bus(bus0));

  // Local command side, steered to one instance by dsel (1 = RD_LAT=0 instance).
  logic        dsel;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  int          cur_wait;
  logic        cur_serr, cur_serr_wait;

  assign bus1.cmd_valid = cmd_valid & ~dsel;
  assign bus0.cmd_valid = cmd_valid & dsel;
  assign bus1.cmd_write = cmd_write;
  assign bus0.cmd_write = cmd_write;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus1.cmd_wdata = cmd_wdata;
  assign bus0.cmd_wdata = cmd_wdata;
  assign bus1.rsp_ready = rsp_ready;
  assign bus0.rsp_ready = rsp_ready;

  // Completer models: pready after cur_wait low ACCESS cycles, optional error.
  logic        acc1, acc0;
  int          acc_cnt1, acc_cnt0;
  logic [31:0] mem1 [0:15];
  logic [31:0] mem0 [0:15];
  logic [31:0] prdata1;

  assign acc1 = bus1.psel & bus1.penable;
  assign acc0 = bus0.psel & bus0.penable;
  assign bus1.pready  = acc1 && (acc_cnt1 >= cur_wait);
  assign bus0.pready  = acc0 && (acc_cnt0 >= cur_wait);
  assign bus1.pslverr = acc1 && (bus1.pready ? cur_serr : cur_serr_wait);
  assign bus0.pslverr = acc0 && (bus0.pready ? cur_serr : cur_serr_wait);
  assign bus1.prdata  = prdata1;
  assign bus0.prdata  = (acc0 && bus0.pready) ? mem0[bus0.paddr[5:2]] : 32'hBAD0_BAD0;

  always @(posedge pclk) begin
    if (preset || !(acc1 && !bus1.pready)) acc_cnt1 <= 0;
    else                                   acc_cnt1 <= acc_cnt1 + 1;
    if (preset || !(acc0 && !bus0.pready)) acc_cnt0 <= 0;
    else                                   acc_cnt0 <= acc_cnt0 + 1;
    if (preset) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= 32'h0;
        mem0[i] <= (i == 3) ? 32'h1234_5678 : 32'h0;
      end
      prdata1 <= 32'hBAD1_BAD1;
    end else begin
      if (acc1 && bus1.pready && !bus1.pslverr && bus1.pwrite) mem1[bus1.paddr[5:2]] <= bus1.pwdata;
      if (acc0 && bus0.pready && !bus0.pslverr && bus0.pwrite) mem0[bus0.paddr[5:2]] <= bus0.pwdata;
      // Registered-read completer: data is valid only in the cycle after the ready edge.
      if (acc1 && bus1.pready && !bus1.pwrite) prdata1 <= mem1[bus1.paddr[5:2]];
      else                                     prdata1 <= 32'hBAD1_BAD1;
    end
  end

  // Observation mux onto the selected instance.
  logic        obs_cmd_ready, obs_rsp_valid, obs_rsp_err, obs_rsp_timeout;
  logic        obs_psel, obs_penable, obs_pwrite;
  logic [31:0] obs_rsp_rdata, obs_paddr, obs_pwdata;

  always_comb begin
    obs_cmd_ready   = dsel ? bus0.cmd_ready   : bus1.cmd_ready;
    obs_rsp_valid   = dsel ? bus0.rsp_valid   : bus1.rsp_valid;
    obs_rsp_err     = dsel ? bus0.rsp_err     : bus1.rsp_err;
    obs_rsp_timeout = dsel ? bus0.rsp_timeout : bus1.rsp_timeout;
    obs_rsp_rdata   = dsel ? bus0.rsp_rdata   : bus1.rsp_rdata;
    obs_psel        = dsel ? bus0.psel        : bus1.psel;
    obs_penable     = dsel ? bus0.penable     : bus1.penable;
    obs_pwrite      = dsel ? bus0.pwrite      : bus1.pwrite;
    obs_paddr       = dsel ? bus0.paddr       : bus1.paddr;
    obs_pwdata      = dsel ? bus0.pwdata      : bus1.pwdata;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          lat0;       // 1 = RD_LAT=0/TIMEOUT=0 instance
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nwait;      // low ACCESS cycles before pready
    bit          serr;       // pslverr with pready
    bit          serr_wait;  // pslverr during wait cycles only
    int          exp_lat;    // accept edge to rsp_valid cycle
    int          exp_pen;    // cycles with penable high
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic run_vec(input vec_t v, input int idx);
    int lat, npsel, npen;
    bit bus_ok;
    string tag;
    dsel          = v.lat0;
    cur_wait      = v.nwait;
    cur_serr      = v.serr;
    cur_serr_wait = v.serr_wait;
    cmd_write     = v.wr;
    cmd_addr      = v.addr;
    cmd_wdata     = v.wdata;
    cmd_valid     = 1'b1;
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, " cmd_ready"}, 32'(obs_cmd_ready), 32'd1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    lat = 1; npsel = 0; npen = 0; bus_ok = 1'b1;
    while (!obs_rsp_valid && lat < 100) begin
      if (obs_psel) npsel++;
      if (obs_penable) npen++;
      if (obs_psel && (obs_paddr !== v.addr || obs_pwrite !== v.wr || obs_pwdata !== v.wdata))
        bus_ok = 1'b0;
      @(posedge pclk); #1;
      lat++;
    end
    $display("txn %0d: %s addr=%h lat=%0d penable=%0d rdata=%h err=%b timeout=%b",
             idx, v.wr ? "WR" : "RD", v.addr, lat, npen, obs_rsp_rdata, obs_rsp_err, obs_rsp_timeout);
    chk({tag, " latency"},     32'(lat),             32'(v.exp_lat));
    chk({tag, " penable_cyc"}, 32'(npen),            32'(v.exp_pen));
    chk({tag, " psel_cyc"},    32'(npsel),           32'(v.exp_pen + 1));
    chk({tag, " bus_stable"},  32'(bus_ok),          32'd1);
    chk({tag, " rsp_rdata"},   obs_rsp_rdata,        v.exp_rdata);
    chk({tag, " rsp_err"},     32'(obs_rsp_err),     32'(v.exp_err));
    chk({tag, " rsp_timeout"}, 32'(obs_rsp_timeout), 32'(v.exp_to));
    @(posedge pclk); #1;
  endtask

  initial begin
    int n;
    bit stable_ok, aborted_rsp;
    logic [31:0] snap_rdata;

    //            lat0 wr addr          wdata         wait serr sw  lat pen rdata         err to
    vecs[0]  = '{1'b0, 1, 32'h04, 32'hDEAD_BEEF,    0, 0, 0,  3,  1, 32'h0,          0, 0};
    vecs[1]  = '{1'b0, 0, 32'h04, 32'h0,            0, 0, 0,  4,  1, 32'hDEAD_BEEF,  0, 0};
    vecs[2]  = '{1'b0, 1, 32'h08, 32'hCAFE_F00D,    2, 0, 1,  5,  3, 32'h0,          0, 0};
    vecs[3]  = '{1'b0, 0, 32'h08, 32'h0,            1, 0, 0,  5,  2, 32'hCAFE_F00D,  0, 0};
    vecs[4]  = '{1'b0, 1, 32'h10, 32'h1111_1111,    0, 1, 0,  3,  1, 32'h0,          1, 0};
    vecs[5]  = '{1'b0, 0, 32'h10, 32'h0,            0, 0, 0,  4,  1, 32'h0,          0, 0};
    vecs[6]  = '{1'b0, 0, 32'h04, 32'h0,            1, 1, 0,  4,  2, 32'h0,          1, 0};
    vecs[7]  = '{1'b0, 1, 32'h0C, 32'h5A5A_0001, 1000, 0, 0, 18, 16, 32'h0,          1, 1};
    vecs[8]  = '{1'b0, 0, 32'h08, 32'h0,           15, 0, 0, 19, 16, 32'hCAFE_F00D,  0, 0};
    vecs[9]  = '{1'b0, 0, 32'h04, 32'h0,           16, 0, 0, 18, 16, 32'h0,          1, 1};
    vecs[10] = '{1'b0, 0, 32'h04, 32'h0,            0, 0, 0,  4,  1, 32'hDEAD_BEEF,  0, 0};
    vecs[11] = '{1'b1, 0, 32'h0C, 32'h0,            3, 0, 0,  6,  4, 32'h1234_5678,  0, 0};
    vecs[12] = '{1'b1, 1, 32'h00, 32'h0F0F_0F0F,   40, 0, 0, 43, 41, 32'h0,          0, 0};
    vecs[13] = '{1'b1, 0, 32'h00, 32'h0,            0, 0, 0,  3,  1, 32'h0F0F_0F0F,  0, 0};
    vecs[14] = '{1'b1, 0, 32'h0C, 32'h0,            0, 1, 0,  3,  1, 32'h0,          1, 0};

    preset = 1'b1; dsel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    cur_wait = 0; cur_serr = 1'b0; cur_serr_wait = 1'b0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    chk("reset cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    chk("reset psel_penable", {30'd0, bus1.psel, bus1.penable}, 32'd0);
    chk("reset rsp_flags", {29'd0, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_timeout}, 32'd0);
    chk("reset paddr", bus1.paddr, 32'd0);
    chk("reset rsp_rdata", bus1.rsp_rdata, 32'd0);
    chk("reset dut0 outputs", {28'd0, bus0.cmd_ready, bus0.psel, bus0.penable, bus0.rsp_valid}, 32'd8);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Response backpressure with the next command already waiting.
    dsel = 1'b0; cur_wait = 0; cur_serr = 1'b0; cur_serr_wait = 1'b0;
    cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5_A5A5; cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge pclk); #1;
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    n = 0;
    while (!bus1.rsp_valid && n < 50) begin @(posedge pclk); #1; n++; end
    chk("bp first rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    snap_rdata = bus1.rsp_rdata;
    stable_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!bus1.rsp_valid || bus1.cmd_ready || bus1.psel || bus1.rsp_err ||
          bus1.rsp_rdata !== snap_rdata || bus1.pwrite !== 1'b1)
        stable_ok = 1'b0;
      @(posedge pclk); #1;
    end
    $display("txn bp: WR addr=00000020 held for 5 cycles, stable=%b", stable_ok);
    chk("bp resp stable", 32'(stable_ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    chk("bp idle after release", {30'd0, bus1.cmd_ready, bus1.rsp_valid}, 32'd2);
    @(posedge pclk); #1;
    chk("bp second accepted", {29'd0, bus1.psel, bus1.penable, bus1.pwrite}, 32'd4);
    cmd_valid = 1'b0;
    n = 0;
    while (!bus1.rsp_valid && n < 50) begin @(posedge pclk); #1; n++; end
    $display("txn bp2: RD addr=00000020 rdata=%h", bus1.rsp_rdata);
    chk("bp second rdata", bus1.rsp_rdata, 32'hA5A5_A5A5);
    @(posedge pclk); #1;

    // Reset while ACCESS is wait-stated.
    cur_wait = 1000;
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h7777_7777; cmd_valid = 1'b1;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst mid penable", 32'(bus1.penable), 32'd1);
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; cur_wait = 0;
    chk("rst mid bus idle", {29'd0, bus1.psel, bus1.penable, bus1.cmd_ready}, 32'd1);
    chk("rst mid paddr", bus1.paddr, 32'd0);
    aborted_rsp = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus1.rsp_valid) aborted_rsp = 1'b1;
      @(posedge pclk); #1;
    end
    $display("txn rst: WR addr=00000030 aborted, late rsp_valid=%b", aborted_rsp);
    chk("rst mid no response", 32'(aborted_rsp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
